// File: rtl/accl_accumulator.sv
// accl_accumulator: N-body force sum for one target body.
// Streams sources through a getAccl pipeline into FP ring accumulators.
module accl_accumulator #(
    parameter int MultTime    = 11,
    parameter int AddTime     = 20,
    parameter int InvSqrtTime = 27,
    parameter int IDX_W       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W:0]   n_src,
    input  logic [IDX_W-1:0] tgt_idx,
    input  logic [63:0]      tgt_x,
    input  logic [63:0]      tgt_y,
    output logic             src_rd,
    output logic [IDX_W-1:0] src_addr,
    input  logic [63:0]      src_x,
    input  logic [63:0]      src_y,
    input  logic [63:0]      src_m,
    output logic             busy,
    output logic             done,
    output logic [63:0]      ax,
    output logic [63:0]      ay
);
    localparam int LATENCY = 2*AddTime + 4*MultTime + InvSqrtTime;
    localparam int CW = $clog2(AddTime + 1);
    localparam int PW = $clog2(AddTime);

    typedef enum logic [2:0] {IDLE, ISSUE, FLUSH, REDUCE, DONE} state_t;
    state_t state, nstate;

    // Behavioural FP64 add, stands in for the vendor adder core.
    function automatic logic [63:0] fp_add(input logic [63:0] a, input logic [63:0] b);
        return $realtobits($bitstoreal(a) + $bitstoreal(b));
    endfunction

    // getAccl datapath: m*d/r^3 with four multiplies on the critical path.
    function automatic logic [127:0] get_accl(input logic [63:0] sx, input logic [63:0] sy,
                                              input logic [63:0] sm, input logic [63:0] tx,
                                              input logic [63:0] ty);
        real dx, dy, inv, f;
        dx  = $bitstoreal(sx) - $bitstoreal(tx);
        dy  = $bitstoreal(sy) - $bitstoreal(ty);
        inv = 1.0 / $sqrt(dx*dx + dy*dy);
        f   = (inv*inv) * ($bitstoreal(sm) * inv);
        return {$realtobits(f*dx), $realtobits(f*dy)};
    endfunction

    logic [IDX_W:0]     n_q;
    logic [IDX_W-1:0]   tgt_q, addr;
    logic [63:0]        tx_q, ty_q;
    logic               v0, sk0, done_q;
    logic [63:0]        cx [LATENCY];
    logic [63:0]        cy [LATENCY];
    logic [LATENCY-1:0] cv, csk;
    logic [63:0]        sx [AddTime];
    logic [63:0]        sy [AddTime];
    logic [AddTime-1:0] av, tv;
    logic [PW-1:0]      td [AddTime];
    logic [63:0]        px [AddTime];
    logic [63:0]        py [AddTime];
    logic [CW-1:0]      wcnt, pcnt, ri;
    logic [PW-1:0]      ia, ib;
    logic               warm, drained, issuing, level_end, capture;
    logic [63:0]        oxa, oxb, oya, oyb;

    assign src_rd    = (state == ISSUE);
    assign src_addr  = addr;
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign warm      = (wcnt == CW'(AddTime));
    assign drained   = !v0 && !(|cv) && !(|av);
    assign capture   = (state == FLUSH) && drained;
    assign issuing   = (state == REDUCE) && (ri < (pcnt >> 1));
    assign level_end = (state == REDUCE) && (pcnt != CW'(1)) && !issuing && !(|tv);
    assign ia        = PW'({ri, 1'b0});
    assign ib        = PW'({ri, 1'b1});

    // Adder operands: tree pairs in REDUCE, otherwise ring accumulation.
    always_comb begin
        oxa = '0;
        oxb = '0;
        oya = '0;
        oyb = '0;
        if (state == REDUCE) begin
            if (issuing) begin
                oxa = px[ia];
                oxb = px[ib];
                oya = py[ia];
                oyb = py[ib];
            end
        end else begin
            if (cv[LATENCY-1] && !csk[LATENCY-1]) begin
                oxa = cx[LATENCY-1];
                oya = cy[LATENCY-1];
            end
            if (warm) begin
                oxb = sx[AddTime-1];
                oyb = sy[AddTime-1];
            end
        end
    end

    // Next-state decode.
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (start) nstate = (n_src == '0) ? DONE : ISSUE;
            ISSUE:   if ({1'b0, addr} == n_q - 1'b1) nstate = FLUSH;
            FLUSH:   if (drained) nstate = REDUCE;
            REDUCE:  if (pcnt == CW'(1)) nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nstate;
    end

    // Job latch, read address, warm-up count, tree bookkeeping and results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q    <= '0;
            tgt_q  <= '0;
            tx_q   <= '0;
            ty_q   <= '0;
            addr   <= '0;
            v0     <= 1'b0;
            sk0    <= 1'b0;
            wcnt   <= '0;
            pcnt   <= '0;
            ri     <= '0;
            done_q <= 1'b0;
            ax     <= '0;
            ay     <= '0;
        end else begin
            v0     <= src_rd;
            sk0    <= src_rd && (addr == tgt_q);
            done_q <= (state == DONE);
            if (state == IDLE && start) begin
                n_q   <= n_src;
                tgt_q <= tgt_idx;
                tx_q  <= tgt_x;
                ty_q  <= tgt_y;
                addr  <= '0;
                wcnt  <= '0;
            end else begin
                if (state == ISSUE && nstate == ISSUE) addr <= addr + 1'b1;
                if ((cv[LATENCY-1] || wcnt != '0) && !warm) wcnt <= wcnt + 1'b1;
            end
            if (capture) begin
                pcnt <= CW'(AddTime);
                ri   <= '0;
            end else if (issuing) begin
                ri <= ri + 1'b1;
            end else if (level_end) begin
                pcnt <= pcnt - (pcnt >> 1);
                ri   <= '0;
            end
            if (state == DONE) begin
                ax <= (n_q == '0) ? '0 : px[0];
                ay <= (n_q == '0) ? '0 : py[0];
            end
        end
    end

    // Valid/skip tags that gate all in-flight datapath values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cv  <= '0;
            csk <= '0;
            av  <= '0;
            tv  <= '0;
        end else begin
            cv  <= {cv[LATENCY-2:0], v0};
            csk <= {csk[LATENCY-2:0], sk0};
            av  <= {av[AddTime-2:0], cv[LATENCY-1]};
            tv  <= {tv[AddTime-2:0], issuing};
        end
    end

    // Datapath pipes, partial capture and tree write-back.
    always_ff @(posedge clk) begin
        {cx[0], cy[0]} <= get_accl(src_x, src_y, src_m, tx_q, ty_q);
        sx[0] <= fp_add(oxa, oxb);
        sy[0] <= fp_add(oya, oyb);
        td[0] <= PW'(ri);
        for (int i = 1; i < LATENCY; i++) begin
            cx[i] <= cx[i-1];
            cy[i] <= cy[i-1];
        end
        for (int i = 1; i < AddTime; i++) begin
            sx[i] <= sx[i-1];
            sy[i] <= sy[i-1];
            td[i] <= td[i-1];
        end
        if (capture) begin
            for (int i = 0; i < AddTime; i++) begin
                px[i] <= sx[i];
                py[i] <= sy[i];
            end
        end else begin
            if (tv[AddTime-1]) begin
                px[td[AddTime-1]] <= sx[AddTime-1];
                py[td[AddTime-1]] <= sy[AddTime-1];
            end
            if (level_end && pcnt[0]) begin
                px[PW'(pcnt >> 1)] <= px[PW'(pcnt - 1'b1)];
                py[PW'(pcnt >> 1)] <= py[PW'(pcnt - 1'b1)];
            end
        end
    end

endmodule

// File: tb/tb_accl_accumulator.sv
// tb_accl_accumulator: directed force-sum jobs checked against
// a double-precision reference model of the pairwise sum.
module tb_accl_accumulator;
    localparam int IDX_W = 10;
    localparam int ADD   = 20;
    localparam int LAT   = 2*ADD + 4*11 + 27;
    localparam int SLACK = LAT + (5 + 2) * (ADD + ADD / 2) + 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [IDX_W:0]   n_src = '0;
    logic [IDX_W-1:0] tgt_idx = '0;
    logic [63:0]      tgt_x = '0;
    logic [63:0]      tgt_y = '0;
    logic             src_rd;
    logic [IDX_W-1:0] src_addr;
    logic [63:0]      src_x = '0;
    logic [63:0]      src_y = '0;
    logic [63:0]      src_m = '0;
    logic             busy, done;
    logic [63:0]      ax, ay;

    always #5 clk = ~clk;

    accl_accumulator dut (
        .clk(clk), .rst(rst), .start(start), .n_src(n_src),
        .tgt_idx(tgt_idx), .tgt_x(tgt_x), .tgt_y(tgt_y),
        .src_rd(src_rd), .src_addr(src_addr),
        .src_x(src_x), .src_y(src_y), .src_m(src_m),
        .busy(busy), .done(done), .ax(ax), .ay(ay)
    );

    real mx [1024];
    real my [1024];
    real mm [1024];

    // Synchronous source RAM: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (src_rd) begin
            src_x <= $realtobits(mx[src_addr]);
            src_y <= $realtobits(my[src_addr]);
            src_m <= $realtobits(mm[src_addr]);
        end
    end

    int  vectors = 0;
    int  miscompares = 0;
    int  m_n = 0;
    real m_ax = 0.0, m_ay = 0.0, m_sc = 0.0;
    int  exp_addr = 0, rd_cnt = 0, done_cnt = 0;

    task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkr(input logic [63:0] act, input real e, input real sc, input string nm);
        real a, tol;
        a   = $bitstoreal(act);
        tol = 1e-12 * ((sc > 1.0) ? sc : 1.0);
        vectors++;
        if (a != a || a - e > tol || e - a > tol) begin
            miscompares++;
            $display("FAIL %s: got %g expected %g", nm, a, e);
        end
    endtask

    // Reference: direct pairwise sum, skipping the target itself.
    task automatic model(input int n, input int ti, input real tx, input real ty);
        real dx, dy, r2, t;
        m_n  = n;
        m_ax = 0.0;
        m_ay = 0.0;
        m_sc = 0.0;
        for (int i = 0; i < n; i++) begin
            if (i != ti) begin
                dx = mx[i] - tx;
                dy = my[i] - ty;
                r2 = dx*dx + dy*dy;
                t  = mm[i] / (r2 * $sqrt(r2));
                m_ax += t * dx;
                m_ay += t * dy;
                m_sc += ((t*dx < 0.0) ? -t*dx : t*dx) + ((t*dy < 0.0) ? -t*dy : t*dy);
            end
        end
        exp_addr = 0;
        rd_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic setsrc(input int i, input real x, input real y, input real m);
        mx[i] = x;
        my[i] = y;
        mm[i] = m;
    endtask

    // Compare process: read sequence every cycle, results on done.
    always @(negedge clk) begin
        if (rst) begin
            if (src_rd) begin
                chk(src_addr == exp_addr[IDX_W-1:0] && exp_addr < m_n,
                    "src_addr", longint'(src_addr), longint'(exp_addr));
                exp_addr++;
                rd_cnt++;
            end
            if (done) begin
                done_cnt++;
                chkr(ax, m_ax, m_sc, "ax_model");
                chkr(ay, m_ay, m_sc, "ay_model");
                chk(rd_cnt == m_n, "read_count", longint'(rd_cnt), longint'(m_n));
            end
        end
    end

    task automatic run(input int n, input int ti, input real tx, input real ty,
                       input bit poke, output int lat);
        model(n, ti, tx, ty);
        @(negedge clk);
        n_src   = n[IDX_W:0];
        tgt_idx = ti[IDX_W-1:0];
        tgt_x   = $realtobits(tx);
        tgt_y   = $realtobits(ty);
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk(busy == 1'b1, "busy_after_start", longint'(busy), 1);
        lat = 1;
        while (!done && lat <= n + SLACK) begin
            start = poke && (lat == 10);
            @(posedge clk);
            #1 lat++;
        end
        start = 1'b0;
        chk(done == 1'b1, "done_in_time", longint'(lat), longint'(n + SLACK));
        @(posedge clk);
        #1;
        chk(done == 1'b0, "done_one_cycle", longint'(done), 0);
        chk(done_cnt == 1, "done_pulses", longint'(done_cnt), 1);
        chk(busy == 1'b0, "idle_after_done", longint'(busy), 0);
        chkr(ax, m_ax, m_sc, "ax_hold");
    endtask

    initial begin
        int lat;
        int ti;
        for (int i = 0; i < 1024; i++) setsrc(i, 0.0, 0.0, 0.0);
        #2;
        chk(busy == 1'b0, "rst_busy", longint'(busy), 0);
        chk(done == 1'b0, "rst_done", longint'(done), 0);
        chk(src_rd == 1'b0, "rst_src_rd", longint'(src_rd), 0);
        chk(src_addr == '0, "rst_src_addr", longint'(src_addr), 0);
        chk(ax == '0, "rst_ax", longint'(ax), 0);
        chk(ay == '0, "rst_ay", longint'(ay), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        setsrc(0, 3.0, 4.0, 125.0);
        run(1, 1, 0.0, 0.0, 1'b0, lat);
        chkr($realtobits(m_ax), 3.0, 3.0, "t1_model_ax");
        chkr($realtobits(m_ay), 4.0, 4.0, "t1_model_ay");
        chkr(ax, 3.0, 3.0, "t1_ax");
        chkr(ay, 4.0, 4.0, "t1_ay");
        chk(rd_cnt == 1, "t1_reads", longint'(rd_cnt), 1);

        model(1, 1, 0.0, 0.0);
        @(negedge clk);
        n_src   = 1;
        tgt_idx = 1;
        tgt_x   = '0;
        tgt_y   = '0;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        rst = 1'b0;
        #1;
        chk(busy == 1'b0, "t5_busy", longint'(busy), 0);
        chk(done == 1'b0, "t5_done", longint'(done), 0);
        chk(src_rd == 1'b0, "t5_src_rd", longint'(src_rd), 0);
        chk(ax == '0, "t5_ax", longint'(ax), 0);
        chk(ay == '0, "t5_ay", longint'(ay), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        run(1, 1, 0.0, 0.0, 1'b0, lat);
        chkr(ax, 3.0, 3.0, "t5_rerun_ax");
        chkr(ay, 4.0, 4.0, "t5_rerun_ay");

        run(0, 0, 1.0, 2.0, 1'b0, lat);
        chk(lat == 2, "t4_latency", longint'(lat), 2);
        chk(ax == '0, "t4_ax_bits", longint'(ax), 0);
        chk(ay == '0, "t4_ay_bits", longint'(ay), 0);
        chk(rd_cnt == 0, "t4_reads", longint'(rd_cnt), 0);

        setsrc(0, 3.0, 4.0, 125.0);
        setsrc(1, -3.0, -4.0, 125.0);
        setsrc(2, 4.0, -3.0, 125.0);
        setsrc(3, -4.0, 3.0, 125.0);
        run(4, 7, 0.0, 0.0, 1'b0, lat);
        chkr(ax, 0.0, 1.0, "t2_ax");
        chkr(ay, 0.0, 1.0, "t2_ay");

        setsrc(0, 13.0, 24.0, 125.0);
        setsrc(1, 7.0, 16.0, 125.0);
        setsrc(2, 10.0, 20.0, 500.0);
        run(3, 2, 10.0, 20.0, 1'b0, lat);
        chkr(ax, 0.0, 1.0, "t3_ax");
        chkr(ay, 0.0, 1.0, "t3_ay");

        for (int i = 0; i < 300; i++) begin
            setsrc(i, real'(int'($urandom_range(0, 1998000)) - 999000) / 1000.0,
                      real'(int'($urandom_range(0, 1998000)) - 999000) / 1000.0,
                      real'(int'($urandom_range(1, 999000))) / 1000.0);
        end
        ti = int'($urandom_range(0, 299));
        run(300, ti, mx[ti], my[ti], 1'b1, lat);
        chk(rd_cnt == 300, "t6_reads", longint'(rd_cnt), 300);

        setsrc(0, 3.0, 4.0, 125.0);
        run(1, 1, 0.0, 0.0, 1'b0, lat);
        chkr(ax, 3.0, 3.0, "t6_b2b_ax");
        chkr(ay, 4.0, 4.0, "t6_b2b_ay");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
